ac_lane_dispatch: RTL and testbench

AC_LANE_DISPATCH -- requirements
Module: ac_lane_dispatch

---
 rtl/ac_pkg.sv | 21 ++
 rtl/ac_sync_fifo.sv | 54 +++++
 rtl/ac_lane_dispatch.sv | 151 +++++++++++++++
 tb/tb_ac_lane_dispatch.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ac_pkg.sv
// Shared types for the lane dispatcher: FSM state encoding, distribution mode,
// and a width helper for counters that must stay at least one bit wide.
package ac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ac_state_t;

  typedef enum logic {
    MODE_PIXEL = 1'b0,
    MODE_ROW   = 1'b1
  } ac_mode_t;

  function automatic int ac_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ac_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; dout shows the head whenever
// empty is low. Push on full and pop on empty are dropped internally.
module ac_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset: contents are only observable while count > 0.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ac_lane_dispatch.sv
// Distributes one frame of pixel beats round-robin over NUM_LANES FWFT FIFOs,
// either per pixel or per row, and checks tlast/user framing against position.
//
// state    | meaning
// ST_IDLE  | waiting for start; mode is captured on start
// ST_RUN   | accepting beats into the target lane FIFO
// ST_DRAIN | last pixel accepted, waiting for every lane FIFO to empty
// ST_DONE  | one-cycle frame_done, then back to idle
module ac_lane_dispatch
  import ac_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int UPSP_DATA_WIDTH = 32,
  parameter int NUM_LANES       = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int SRC_IMG_WIDTH   = 960,
  parameter int SRC_IMG_HEIGHT  = 540
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 mode,
  output logic                                 busy,
  output logic                                 frame_done,
  output logic                                 err_sync,
  input  logic                                 s_axis_tvalid,
  output logic                                 s_axis_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]           s_axis_tdata,
  input  logic                                 s_axis_tlast,
  input  logic                                 s_axis_user,
  output logic [NUM_LANES-1:0]                 ac_upsp_rvalid,
  output logic [NUM_LANES*UPSP_DATA_WIDTH-1:0] ac_upsp_rdata,
  input  logic [NUM_LANES-1:0]                 upsp_ac_rd
);

  localparam int CW = ac_bits(SRC_IMG_WIDTH);
  localparam int RW = ac_bits(SRC_IMG_HEIGHT);
  localparam int LW = ac_bits(NUM_LANES);
  localparam logic [CW-1:0] COL_LAST  = CW'(SRC_IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(SRC_IMG_HEIGHT - 1);
  localparam logic [LW-1:0] LANE_LAST = LW'(NUM_LANES - 1);

  ac_state_t      state, state_nxt;
  ac_mode_t       mode_q;
  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [LW-1:0]  lane;

  logic [NUM_LANES-1:0] push_vec;
  logic [NUM_LANES-1:0] pop_vec;
  logic [NUM_LANES-1:0] full_vec;
  logic [NUM_LANES-1:0] empty_vec;

  logic accept;
  logic start_ok;
  logic col_last;
  logic row_last;
  logic first_px;
  logic lane_adv;
  logic framing_bad;

  assign accept      = s_axis_tvalid & s_axis_tready;
  assign start_ok    = (state == ST_IDLE) & start;
  assign col_last    = (col == COL_LAST);
  assign row_last    = (row == ROW_LAST);
  assign first_px    = (col == '0) & (row == '0);
  assign lane_adv    = (mode_q == MODE_PIXEL) ? 1'b1 : col_last;
  assign framing_bad = (s_axis_tlast != col_last) | (s_axis_user != first_px);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_RUN;
      ST_RUN:   if (accept && col_last && row_last) state_nxt = ST_DRAIN;
      ST_DRAIN: if (&empty_vec) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // A same-cycle pop does not release a full lane: full_vec is registered state.
  always_comb begin
    busy          = 1'b0;
    frame_done    = 1'b0;
    s_axis_tready = 1'b0;
    case (state)
      ST_RUN: begin
        busy          = 1'b1;
        s_axis_tready = ~full_vec[lane];
      end
      ST_DRAIN: busy       = 1'b1;
      ST_DONE:  frame_done = 1'b1;
      default: ;
    endcase
  end

  // Position counters follow accepted beats only; tlast never resyncs them.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_PIXEL;
      col    <= '0;
      row    <= '0;
      lane   <= '0;
    end else if (start_ok) begin
      mode_q <= ac_mode_t'(mode);
      col    <= '0;
      row    <= '0;
      lane   <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
      if (lane_adv) lane <= (lane == LANE_LAST) ? '0 : lane + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                         err_sync <= 1'b0;
    else if (start_ok)               err_sync <= 1'b0;
    else if (accept && framing_bad)  err_sync <= 1'b1;
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign push_vec[i]       = accept & (lane == LW'(i));
    assign pop_vec[i]        = upsp_ac_rd[i] & ~empty_vec[i];
    assign ac_upsp_rvalid[i] = ~empty_vec[i];

    ac_sync_fifo #(
      .WIDTH (UPSP_DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_vec[i]),
      .din   (UPSP_DATA_WIDTH'(s_axis_tdata)),
      .pop   (pop_vec[i]),
      .dout  (ac_upsp_rdata[i*UPSP_DATA_WIDTH +: UPSP_DATA_WIDTH]),
      .full  (full_vec[i]),
      .empty (empty_vec[i])
    );
  end

endmodule

// File: tb/tb_ac_lane_dispatch.sv
// Directed bench for ac_lane_dispatch on an 8x4 frame with 4 lanes of depth 4;
// tdata carries the pixel index so each lane's pop order can be predicted.
module tb_ac_lane_dispatch;

  localparam int DW = 32;
  localparam int NL = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              mode;
  logic              busy;
  logic              frame_done;
  logic              err_sync;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic [DW-1:0]     s_axis_tdata;
  logic              s_axis_tlast;
  logic              s_axis_user;
  logic [NL-1:0]     ac_upsp_rvalid;
  logic [NL*DW-1:0]  ac_upsp_rdata;
  logic [NL-1:0]     upsp_ac_rd;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] got [NL][$];

  always #5 clk = ~clk;

  ac_lane_dispatch #(
    .AXIS_DATA_WIDTH (DW),
    .UPSP_DATA_WIDTH (DW),
    .NUM_LANES       (NL),
    .FIFO_DEPTH      (4),
    .SRC_IMG_WIDTH   (8),
    .SRC_IMG_HEIGHT  (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .mode           (mode),
    .busy           (busy),
    .frame_done     (frame_done),
    .err_sync       (err_sync),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_user    (s_axis_user),
    .ac_upsp_rvalid (ac_upsp_rvalid),
    .ac_upsp_rdata  (ac_upsp_rdata),
    .upsp_ac_rd     (upsp_ac_rd)
  );

  // Record every pop that will occur at the coming rising edge.
  always @(negedge clk) begin
    for (int i = 0; i < NL; i++)
      if (ac_upsp_rvalid[i] && upsp_ac_rd[i]) got[i].push_back(ac_upsp_rdata[i*DW +: DW]);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_got();
    for (int i = 0; i < NL; i++) got[i].delete();
  endtask

  task automatic start_frame(input logic m);
    @(posedge clk); #1;
    start = 1'b1;
    mode  = m;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Drive pixels first..last-1; pixel 'flip' gets an inverted tlast.
  task automatic drive_beats(input int first, input int last, input int flip);
    int n;
    for (int p = first; p < last; p++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = DW'(p);
      s_axis_tlast  = ((p % 8) == 7) ^ (p == flip);
      s_axis_user   = (p == 0);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!s_axis_tready && n < 100);
      check($sformatf("accept_px%0d", p), {31'd0, s_axis_tready}, 32'd1);
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_user   = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!frame_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("frame_done_seen", {31'd0, frame_done}, 32'd1);
    @(negedge clk);
    check("frame_done_pulse", {31'd0, frame_done}, 32'd0);
    check("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  // Mode 0: lane l gets l, l+4, ..., l+28. Mode 1: lane l gets 8l..8l+7.
  task automatic check_frame(input string tag, input logic m);
    logic [31:0] exp_v;
    logic [31:0] obs_v;
    for (int l = 0; l < NL; l++) begin
      check($sformatf("%s_lane%0d_count", tag, l), got[l].size(), 32'd8);
      for (int k = 0; k < 8; k++) begin
        exp_v = m ? 32'(8 * l + k) : 32'(l + 4 * k);
        obs_v = (k < got[l].size()) ? got[l][k] : 32'hDEAD_BEEF;
        check($sformatf("%s_lane%0d_item%0d", tag, l, k), obs_v, exp_v);
      end
    end
    clear_got();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tready"}, {31'd0, s_axis_tready}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, frame_done}, 32'd0);
    check({tag, "_err"}, {31'd0, err_sync}, 32'd0);
    check({tag, "_rvalid"}, {28'd0, ac_upsp_rvalid}, 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    mode          = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_user   = 1'b0;
    upsp_ac_rd    = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Pixel interleave, all lanes always reading.
    start_frame(1'b0);
    @(negedge clk);
    check("run_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    drive_beats(0, 32, -1);
    wait_done();
    check("m0_err", {31'd0, err_sync}, 32'd0);
    check_frame("m0", 1'b0);

    // Row interleave.
    start_frame(1'b1);
    drive_beats(0, 32, -1);
    wait_done();
    check("m1_err", {31'd0, err_sync}, 32'd0);
    check_frame("m1", 1'b1);

    // Lane 2 not reading: it fills with 2,6,10,14 and blocks pixel 18.
    upsp_ac_rd = 4'b1011;
    start_frame(1'b0);
    drive_beats(0, 18, -1);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'd18;
    s_axis_tlast  = 1'b0;
    s_axis_user   = 1'b0;
    @(negedge clk);
    check("stall_tready", {31'd0, s_axis_tready}, 32'd0);
    check("stall_lane2_valid", {31'd0, ac_upsp_rvalid[2]}, 32'd1);
    check("stall_lane2_head", ac_upsp_rdata[2*DW +: DW], 32'd2);
    repeat (3) @(negedge clk);
    check("stall_tready_held", {31'd0, s_axis_tready}, 32'd0);
    @(posedge clk); #1;
    upsp_ac_rd = 4'hF;
    drive_beats(18, 32, -1);
    wait_done();
    check_frame("stall", 1'b0);

    // Wrong tlast on pixel 5: sticky error, distribution unaffected.
    start_frame(1'b0);
    drive_beats(0, 5, -1);
    @(negedge clk);
    check("err_before", {31'd0, err_sync}, 32'd0);
    @(posedge clk); #1;
    drive_beats(5, 6, 5);
    @(negedge clk);
    check("err_set", {31'd0, err_sync}, 32'd1);
    @(posedge clk); #1;
    drive_beats(6, 32, -1);
    wait_done();
    check("err_sticky", {31'd0, err_sync}, 32'd1);
    check_frame("err", 1'b0);
    start_frame(1'b1);
    @(negedge clk);
    check("err_cleared", {31'd0, err_sync}, 32'd0);
    @(posedge clk); #1;
    drive_beats(0, 32, -1);
    wait_done();
    check_frame("after_err", 1'b1);

    // Reset after 10 beats, then a clean frame restarts at pixel 0, lane 0.
    start_frame(1'b1);
    drive_beats(0, 10, -1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    clear_got();
    start_frame(1'b0);
    drive_beats(0, 32, -1);
    wait_done();
    check_frame("post_rst", 1'b0);

    // Start with toggled mode during RUN must be ignored.
    start_frame(1'b0);
    drive_beats(0, 10, -1);
    start = 1'b1;
    mode  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mode  = 1'b0;
    drive_beats(10, 32, -1);
    wait_done();
    check_frame("start_in_run", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
